// File: rtl/slot_win_sched_pkg.sv
// Shared types and helpers for the slot/window round-robin scheduler.
// Requesters and slots are both fixed at eight.
package slot_win_pkg;

    localparam int N_REQ  = 8;
    localparam int N_SLOT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_GRANT,
        ST_GAP
    } state_t;

    // Row k holds the window mask of requester k; bit s enables slot s.
    typedef logic [N_REQ-1:0][N_SLOT-1:0] win_arr_t;

    function automatic logic [N_REQ-1:0] build_elig(
        input logic [N_REQ-1:0] req,
        input win_arr_t         win,
        input logic [2:0]       slot
    );
        logic [N_REQ-1:0] elig;
        elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            elig[k] = req[k] & win[k][slot];
        end
        return elig;
    endfunction

endpackage

// File: rtl/slot_win_sched_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
// Window masks keep one signal per requester, matching the board-level naming.
interface slot_win_sched_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [7:0]       req_flag;
    logic [7:0]       time_win1;
    logic [7:0]       time_win2;
    logic [7:0]       time_win3;
    logic [7:0]       time_win4;
    logic [7:0]       time_win5;
    logic [7:0]       time_win6;
    logic [7:0]       time_win7;
    logic [7:0]       time_win8;
    logic [7:0]       done;
    logic [7:0]       gnt;
    logic             gnt_vld;
    logic [2:0]       slot_idx;
    logic             abort;
    logic [CNT_W-1:0] abort_cnt;

    modport master (
        output en, req_flag, done,
        output time_win1, time_win2, time_win3, time_win4,
        output time_win5, time_win6, time_win7, time_win8,
        input  gnt, gnt_vld, slot_idx, abort, abort_cnt
    );

    modport slave (
        input  en, req_flag, done,
        input  time_win1, time_win2, time_win3, time_win4,
        input  time_win5, time_win6, time_win7, time_win8,
        output gnt, gnt_vld, slot_idx, abort, abort_cnt
    );

endinterface

// File: rtl/slot_win_sched_rr_pick8.sv
// Combinational round-robin picker over eight requesters.
// Search begins one past last_i and wraps modulo eight.
module rr_pick8 (
    input  logic [7:0] elig_i,
    input  logic [2:0] last_i,
    output logic [7:0] pick_oh_o,
    output logic [2:0] pick_idx_o,
    output logic       any_o
);

    logic [2:0] idx;
    logic       found;

    always_comb begin
        idx        = '0;
        found      = 1'b0;
        pick_idx_o = last_i;
        for (int i = 1; i <= 8; i++) begin
            idx = last_i + 3'(i);
            if (!found && elig_i[idx]) begin
                found      = 1'b1;
                pick_idx_o = idx;
            end
        end
        any_o     = found;
        pick_oh_o = found ? (8'b1 << pick_idx_o) : 8'b0;
    end

endmodule

// File: rtl/slot_win_sched.sv
// Time-slot scheduler: eight slots per frame, one round-robin grant per slot,
// released by done/drop or pre-empted at the slot boundary.
module slot_win_sched
    import slot_win_pkg::*;
#(
    parameter int SLOT_CYC = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    slot_win_sched_if.slave  bus
);

    localparam int              CYC_W    = $clog2(SLOT_CYC);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYC - 1);

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       slot_q, slot_d;
    logic [2:0]       last_q, last_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;

    logic [7:0] elig;
    logic [7:0] pick_oh;
    logic [2:0] pick_idx;
    logic       pick_any;
    logic       slot_end;

    assign elig = build_elig(bus.req_flag,
                             {bus.time_win8, bus.time_win7, bus.time_win6, bus.time_win5,
                              bus.time_win4, bus.time_win3, bus.time_win2, bus.time_win1},
                             slot_q);

    rr_pick8 u_pick (
        .elig_i     (elig),
        .last_i     (last_q),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx),
        .any_o      (pick_any)
    );

    assign slot_end = (cyc_q == CYC_LAST);

    // Counters hold in IDLE so that ARB is always entered with cyc_cnt = 0.
    always_comb begin
        cyc_d  = cyc_q;
        slot_d = slot_q;
        if (!bus.en) begin
            cyc_d  = '0;
            slot_d = '0;
        end else if (state_q != ST_IDLE) begin
            if (slot_end) begin
                cyc_d  = '0;
                slot_d = slot_q + 3'd1;
            end else begin
                cyc_d  = cyc_q + CYC_W'(1);
            end
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        abort_d     = 1'b0;
        abort_cnt_d = abort_cnt_q;

        if (!bus.en) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARB;
                ST_ARB: begin
                    if (pick_any && !slot_end) begin
                        gnt_d     = pick_oh;
                        gnt_idx_d = pick_idx;
                        state_d   = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Release outranks pre-emption when both land on the last cycle.
                    if (bus.done[gnt_idx_q] || !bus.req_flag[gnt_idx_q]) begin
                        gnt_d   = '0;
                        last_d  = gnt_idx_q;
                        state_d = ST_GAP;
                    end else if (slot_end) begin
                        gnt_d   = '0;
                        last_d  = gnt_idx_q;
                        abort_d = 1'b1;
                        if (abort_cnt_q != '1) begin
                            abort_cnt_d = abort_cnt_q + CNT_W'(1);
                        end
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: state_d = ST_ARB;
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            slot_q      <= '0;
            last_q      <= 3'd7;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            abort_q     <= 1'b0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            slot_q      <= slot_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            abort_q     <= abort_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_vld   = |gnt_q;
    assign bus.slot_idx  = slot_q;
    assign bus.abort     = abort_q;
    assign bus.abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_slot_win_sched.sv
// Self-checking bench for slot_win_sched: round-robin vector table with a grant
// scoreboard, plus hand-written slot-boundary, disable and reset sequences.
module tb_slot_win_sched;

    logic clk;
    logic rst_n;

    slot_win_sched_if #(.CNT_W(8)) bus ();

    slot_win_sched #(.SLOT_CYC(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] exp_gnt;
    } rr_vec_t;

    int         checks;
    int         errors;
    int         edge_n;
    int         abort_seen;
    bit         sb_on;
    logic       prev_vld;
    logic [7:0] sb_exp;
    logic [7:0] exp_q[$];
    rr_vec_t    tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h, required %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic set_wins(input logic [7:0] w);
        bus.time_win1 = w; bus.time_win2 = w; bus.time_win3 = w; bus.time_win4 = w;
        bus.time_win5 = w; bus.time_win6 = w; bus.time_win7 = w; bus.time_win8 = w;
    endtask

    task automatic do_reset();
        bus.en       = 1'b0;
        bus.req_flag = 8'h00;
        bus.done     = 8'h00;
        set_wins(8'hFF);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Raise en so that the next rising edge is edge 0.
    task automatic start();
        bus.en = 1'b1;
        edge_n = -1;
    endtask

    // Scoreboard: every new grant pops the next expected one-hot value.
    initial begin
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (bus.gnt_vld && !prev_vld) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got gnt %02h, required no grant", bus.gnt);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        check("rr_grant", {24'd0, bus.gnt}, {24'd0, sb_exp});
                    end
                end
                if (bus.abort) abort_seen++;
            end
            prev_vld = bus.gnt_vld;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int  w;
        logic [7:0] eg;
        logic       ea;

        checks     = 0;
        errors     = 0;
        edge_n     = 0;
        abort_seen = 0;
        sb_on      = 1'b0;

        tbl[0]  = '{8'h0D, 8'h01};
        tbl[1]  = '{8'h0D, 8'h04};
        tbl[2]  = '{8'h0D, 8'h08};
        tbl[3]  = '{8'h0D, 8'h01};
        tbl[4]  = '{8'h0D, 8'h04};
        tbl[5]  = '{8'h0D, 8'h08};
        tbl[6]  = '{8'hF0, 8'h10};
        tbl[7]  = '{8'h81, 8'h80};
        tbl[8]  = '{8'h81, 8'h01};
        tbl[9]  = '{8'h02, 8'h02};
        tbl[10] = '{8'h03, 8'h01};
        tbl[11] = '{8'hFF, 8'h02};

        // Reset values
        do_reset();
        check("rst_gnt",       {24'd0, bus.gnt}, 32'h0);
        check("rst_gnt_vld",   {31'd0, bus.gnt_vld}, 32'h0);
        check("rst_abort",     {31'd0, bus.abort}, 32'h0);
        check("rst_abort_cnt", {24'd0, bus.abort_cnt}, 32'h0);
        check("rst_slot_idx",  {29'd0, bus.slot_idx}, 32'h0);

        // Single requester: grant from edge 1, done after 3 cycles, 1-cycle gap
        bus.req_flag = 8'h01;
        start();
        run_to(0);
        check("single_edge0", {24'd0, bus.gnt}, 32'h0);
        run_to(1);
        check("single_first", {24'd0, bus.gnt}, 32'h01);
        check("single_vld",   {31'd0, bus.gnt_vld}, 32'h1);
        run_to(3);
        check("single_hold",  {24'd0, bus.gnt}, 32'h01);
        bus.done = 8'h01;
        tick();
        bus.done = 8'h00;
        check("single_gap",   {24'd0, bus.gnt}, 32'h0);
        check("single_noab",  {31'd0, bus.abort}, 32'h0);
        run_to(5);
        check("single_arb",   {24'd0, bus.gnt}, 32'h0);
        run_to(6);
        check("single_regnt", {24'd0, bus.gnt}, 32'h01);
        check("single_cnt",   {24'd0, bus.abort_cnt}, 32'h0);

        // Round-robin vector table, immediate done on every grant
        do_reset();
        start();
        abort_seen = 0;
        sb_on      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.req_flag = tbl[i].req;
            exp_q.push_back(tbl[i].exp_gnt);
            w = 0;
            while (w < 40 && !bus.gnt_vld) begin
                tick();
                w++;
            end
            if (!bus.gnt_vld) begin
                checks++;
                errors++;
                $display("FAIL rr_timeout vec %0d: got no grant, required %02h", i, tbl[i].exp_gnt);
            end
            bus.done = bus.gnt;
            tick();
            bus.done = 8'h00;
        end
        tick();
        sb_on = 1'b0;
        check("rr_queue_empty", exp_q.size(), 32'd0);
        check("rr_no_abort",    abort_seen, 32'd0);
        check("rr_abort_cnt",   {24'd0, bus.abort_cnt}, 32'h0);

        // Window filter over one frame; a mid-grant window change must not revoke
        do_reset();
        set_wins(8'h00);
        bus.time_win2 = 8'h04;
        bus.time_win5 = 8'h01;
        bus.req_flag  = 8'h12;
        start();
        for (int n = 0; n < 128; n++) begin
            run_to(n);
            eg = (n >= 1 && n <= 15) ? 8'h10 : ((n >= 33 && n <= 47) ? 8'h02 : 8'h00);
            ea = (n == 16 || n == 48);
            check("win_gnt",   {24'd0, bus.gnt}, {24'd0, eg});
            check("win_abort", {31'd0, bus.abort}, {31'd0, ea});
            check("win_slot",  {29'd0, bus.slot_idx}, 32'(n / 16));
            if (n == 5) bus.time_win5 = 8'h00;
        end
        check("win_abort_cnt", {24'd0, bus.abort_cnt}, 32'd2);

        // Done coincident with the slot's last cycle; ARB in the last cycle must wait
        do_reset();
        bus.req_flag = 8'h01;
        start();
        run_to(5);
        bus.done = 8'h02;
        tick();
        bus.done = 8'h00;
        check("sim_foreign_done", {24'd0, bus.gnt}, 32'h01);
        run_to(15);
        check("sim_hold_last", {24'd0, bus.gnt}, 32'h01);
        bus.done = 8'h01;
        tick();
        bus.done = 8'h00;
        check("sim_rel_gnt",   {24'd0, bus.gnt}, 32'h0);
        check("sim_rel_abort", {31'd0, bus.abort}, 32'h0);
        check("sim_rel_cnt",   {24'd0, bus.abort_cnt}, 32'h0);
        run_to(18);
        check("sim_regrant", {24'd0, bus.gnt}, 32'h01);
        run_to(29);
        bus.done = 8'h01;
        tick();
        bus.done = 8'h00;
        run_to(32);
        check("sim_no_last_grant", {24'd0, bus.gnt}, 32'h0);
        run_to(33);
        check("sim_next_slot", {24'd0, bus.gnt}, 32'h01);

        // Disable mid-grant preserves the pointer
        do_reset();
        bus.req_flag = 8'h06;
        start();
        run_to(1);
        check("dis_first", {24'd0, bus.gnt}, 32'h02);
        bus.done = 8'h02;
        tick();
        bus.done = 8'h00;
        run_to(4);
        check("dis_second", {24'd0, bus.gnt}, 32'h04);
        run_to(16);
        check("dis_preempt_gnt", {24'd0, bus.gnt}, 32'h0);
        check("dis_preempt_ab",  {31'd0, bus.abort}, 32'h1);
        check("dis_preempt_cnt", {24'd0, bus.abort_cnt}, 32'd1);
        run_to(18);
        check("dis_third", {24'd0, bus.gnt}, 32'h02);
        check("dis_slot1", {29'd0, bus.slot_idx}, 32'd1);
        run_to(20);
        bus.en = 1'b0;
        tick();
        check("dis_gnt",   {24'd0, bus.gnt}, 32'h0);
        check("dis_abort", {31'd0, bus.abort}, 32'h0);
        check("dis_slot",  {29'd0, bus.slot_idx}, 32'd0);
        check("dis_cnt",   {24'd0, bus.abort_cnt}, 32'd1);
        tick();
        bus.en = 1'b1;
        tick();
        check("reen_arb", {24'd0, bus.gnt}, 32'h0);
        tick();
        check("reen_ptr", {24'd0, bus.gnt}, 32'h02);

        // Abort counter saturation, then asynchronous reset mid-grant
        do_reset();
        bus.req_flag = 8'h01;
        start();
        run_to(16 * 260);
        check("sat_abort_cnt", {24'd0, bus.abort_cnt}, 32'hFF);
        run_to(16 * 260 + 5);
        check("sat_gnt", {24'd0, bus.gnt}, 32'h01);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gnt",       {24'd0, bus.gnt}, 32'h0);
        check("arst_gnt_vld",   {31'd0, bus.gnt_vld}, 32'h0);
        check("arst_abort",     {31'd0, bus.abort}, 32'h0);
        check("arst_abort_cnt", {24'd0, bus.abort_cnt}, 32'h0);
        check("arst_slot",      {29'd0, bus.slot_idx}, 32'h0);
        bus.req_flag = 8'h81;
        rst_n = 1'b1;
        edge_n = -1;
        run_to(0);
        check("arst_edge0", {24'd0, bus.gnt}, 32'h0);
        run_to(1);
        check("arst_first", {24'd0, bus.gnt}, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_win_sched.md
# slot_win_sched

Sequential time-slot scheduler for eight requesters sharing one resource. A frame is divided into 8 slots, and each requester carries an 8-bit window mask that says which slots it may use. Each slot, the block grants the resource to one eligible requester using round-robin order, holds the grant until the requester is done or the slot ends, and pre-empts at the slot boundary. It sits in front of the shared resource and replaces static lowest-index minimum selection with fair, time-bounded access.

## Interface
- `SLOT_CYC`, default 16: clock cycles per slot; legal range ≥ 4.
- `CNT_W`, default 8: width of the saturating abort counter.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: scheduler enable. Level-sensitive; 0 flushes to idle.
- `req_flag` in 8: request level; bit k is requester k.
- `time_win1`..`time_win8` in 8 each: window mask of requesters 0..7. Bit s = 1 means the requester is allowed in slot s.
- `done` in 8: one-cycle release pulse from requester k. Only meaningful while `gnt[k]` = 1.
- `gnt` out 8: one-hot grant, or 0.
- `gnt_vld` out 1: OR of `gnt`.
- `slot_idx` out 3: current slot number, 0..7.
- `abort` out 1: one-cycle pulse when a grant is pre-empted.
- `abort_cnt` out CNT_W: saturating count of aborts.

## Operation
- **Counters**
  - `cyc_cnt` runs 0..SLOT_CYC-1.
  - When `cyc_cnt` wraps, `slot_idx` increments and wraps 7 → 0.
  - Both counters run only while `en` = 1. They hold at 0 while `en` = 0.
- **Eligibility:** `elig[k]` = `req_flag[k]` & `time_win(k+1)[slot_idx]`.
- **Round-robin pick**
  - Search starts at `last` + 1 and wraps modulo 8.
  - `last` is updated to k whenever requester k's grant ends, whether by done, drop or abort.
- **FSM states:** IDLE, ARB, GRANT, GAP.
  - **IDLE:** `gnt` = 0. Moves to ARB on `en` = 1.
  - **ARB:** if `elig` ≠ 0 and `cyc_cnt` ≠ SLOT_CYC-1, load `gnt` with the pick and go to GRANT. Otherwise stay in ARB.
  - **GRANT**, with k the granted requester; checked in this priority order:
    1. `done[k]` = 1, or `req_flag[k]` = 0: release. Go to GAP with no abort.
    2. `cyc_cnt` = SLOT_CYC-1: pre-empt. Go to GAP, pulse `abort`, increment `abort_cnt`.
    3. Otherwise hold the grant.
  - **GAP:** `gnt` = 0 for exactly one cycle, then ARB.
  - **Any state:** `en` = 0 goes to IDLE. `gnt` clears next cycle, with no `abort` and `last` unchanged.
- **Boundary rules**
  - `done` and the slot end in the same cycle: `done` wins, with no abort.
  - `done[j]` for a non-granted j is ignored.
  - A window change mid-grant does not revoke the grant. It takes effect at the next ARB.
  - `abort_cnt` saturates at all-ones.

## Timing
- **Reset values:**
  - `gnt` = 0, `gnt_vld` = 0, `abort` = 0, `abort_cnt` = 0.
  - `slot_idx` = 0, `cyc_cnt` = 0.
  - FSM = IDLE, `last` = 7, so requester 0 has first priority.
- **Start-up:** `en` is sampled high at edge 0. FSM enters ARB with `cyc_cnt` = 0. The first `gnt` can appear at edge 1.
- **Grant latency:** `elig` sampled in ARB at edge c gives `gnt` valid after edge c+1.
- **Release latency:** `done` sampled at edge c gives `gnt` = 0 after edge c+1 (GAP). The next grant comes no earlier than edge c+3.
- **Abort timing:** `abort` is high for the same cycle in which `gnt` first reads 0.
- **No last-cycle grants:** no grant is ever issued for the last cycle of a slot.
- **Reset mid-grant:** outputs go to reset values immediately and asynchronously.

## Structure
- **Package `slot_win_pkg`:**
  - `N_REQ` = 8, `N_SLOT` = 8.
  - FSM state enum.
  - Helper function that builds the `elig` vector from the eight masks and `slot_idx`.
- **Sub-module `rr_pick8`:** combinational; takes `elig`[7:0] and `last`[2:0], returns a one-hot pick and its index. Instantiated once.
- **Top level:** counters, FSM, `last` register, abort counter.

## Test plan
- **Single requester:** `req_flag` = 8'h01, `time_win1` = 8'hFF, `done` after 3 cycles of grant. Expect `gnt` = 01 from edge 1, GAP 1 cycle, regrant; `abort` never asserts.
- **Round-robin:** `req_flag` = 8'h0D, all windows 8'hFF, immediate `done` on each grant. Expect grant order 0, 2, 3, 0, 2, 3.
- **Window filter:** requester 1 window 8'h04 and requester 4 window 8'h01, both requesting, no `done`. Expect requester 4 granted in slot 0, requester 1 in slot 2, nobody in the other slots; `abort` at the end of slots 0 and 2; `abort_cnt` = 2 after one frame.
- **Simultaneous release:** `done[k]` coincident with `cyc_cnt` = 15. Expect no `abort`, `abort_cnt` unchanged, and no grant in that slot's final cycle.
- **Disable:** drop `en` mid-grant. Expect `gnt` = 0 next cycle, `slot_idx` = 0, no `abort`; re-enable and the arbitration pointer is preserved.
- **Reset mid-operation:** assert `rst_n` low mid-grant. Expect every output at its reset value asynchronously; the next first grant goes to requester 0.
